// File: rtl/nes_joypad_port_if.sv
// CPU bus bundle for the joypad register: the CPU drives address/control/write
// data, and the port returns registered read data with a one-cycle valid pulse.
interface nes_joypad_port_if;
  logic        cpu_cycle_en;
  logic [15:0] cpu_addr;
  logic        cpu_rw_n;
  logic [7:0]  cpu_dout;
  logic [7:0]  data_out;
  logic        data_oe;

  // CPU side of the bus
  modport master (
    output cpu_cycle_en, cpu_addr, cpu_rw_n, cpu_dout,
    input  data_out, data_oe
  );

  // Joypad port side of the bus
  modport slave (
    input  cpu_cycle_en, cpu_addr, cpu_rw_n, cpu_dout,
    output data_out, data_oe
  );
endinterface

// File: rtl/nes_joypad_port.sv
// NES player-1 controller register driven from a USB HID keycode.
// A strobe write latches the mapped buttons; each read shifts one button out
// on bit 0 (A first), with 1s shifted in behind so reads past eight return 1.
module nes_joypad_port #(
  parameter logic [15:0] PORT_ADDR = 16'h4016,
  parameter logic [7:0]  OPEN_BUS  = 8'h40
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [7:0]        keycode,
  nes_joypad_port_if.slave  bus,
  output logic [7:0]        buttons_debug,
  output logic [3:0]        read_count
);

  localparam logic [15:0] PORT_ADDR_P1 = PORT_ADDR + 16'd1;

  logic [7:0] buttons;
  logic       strobe;
  logic [7:0] shreg;
  logic       write_hit;
  logic       read_hit;
  logic       read_hit_p1;
  logic       unused_dout_bits;

  // Only bit 0 of a strobe write carries meaning.
  assign unused_dout_bits = ^bus.cpu_dout[7:1];

  assign write_hit   = bus.cpu_cycle_en & ~bus.cpu_rw_n & (bus.cpu_addr == PORT_ADDR);
  assign read_hit    = bus.cpu_cycle_en &  bus.cpu_rw_n & (bus.cpu_addr == PORT_ADDR);
  assign read_hit_p1 = bus.cpu_cycle_en &  bus.cpu_rw_n & (bus.cpu_addr == PORT_ADDR_P1);

  // Keycode to button vector {Right,Left,Down,Up,Start,Select,B,A}.
  always_comb begin
    buttons = 8'h00;
    case (keycode)
      8'h0D:   buttons = 8'b0000_0001; // A
      8'h0E:   buttons = 8'b0000_0010; // B
      8'h2C:   buttons = 8'b0000_0100; // Select
      8'h28:   buttons = 8'b0000_1000; // Start
      8'h1A:   buttons = 8'b0001_0000; // Up
      8'h16:   buttons = 8'b0010_0000; // Down
      8'h04:   buttons = 8'b0100_0000; // Left
      8'h07:   buttons = 8'b1000_0000; // Right
      default: buttons = 8'h00;
    endcase
  end

  assign buttons_debug = buttons;

  // Strobe, shift register and read counter. While strobe is high the register
  // tracks the live buttons every cycle, so the cycle of the 1->0 write also
  // captures the buttons seen in that cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      strobe     <= 1'b0;
      shreg      <= 8'h00;
      read_count <= 4'd0;
    end else begin
      if (strobe) begin
        shreg      <= buttons;
        read_count <= 4'd0;
      end else if (read_hit) begin
        shreg      <= {1'b1, shreg[7:1]};
        read_count <= (read_count == 4'd8) ? 4'd8 : read_count + 4'd1;
      end
      if (write_hit) begin
        strobe <= bus.cpu_dout[0];
      end
    end
  end

  // Registered read data with a single-cycle valid pulse; data holds between reads.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.data_out <= 8'h00;
      bus.data_oe  <= 1'b0;
    end else begin
      bus.data_oe <= read_hit | read_hit_p1;
      if (read_hit) begin
        bus.data_out <= {OPEN_BUS[7:1], (strobe ? buttons[0] : shreg[0])};
      end else if (read_hit_p1) begin
        bus.data_out <= {OPEN_BUS[7:1], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_nes_joypad_port.sv
// Self-checking bench for nes_joypad_port: a button-index model of the
// controller is compared against the DUT every cycle, and directed sequences
// are pinned with hand-computed literal values.
module tb_nes_joypad_port;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [7:0] buttons_debug;
  logic [3:0] read_count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  nes_joypad_port_if bus();

  nes_joypad_port #(.PORT_ADDR(16'h4016), .OPEN_BUS(8'h40)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .keycode(keycode),
    .bus(bus),
    .buttons_debug(buttons_debug),
    .read_count(read_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Controller model: a snapshot of the buttons plus the number of reads
  // taken since the snapshot. Read n returns button n, or 1 beyond eight.
  function automatic logic [7:0] map_key(input logic [7:0] k);
    case (k)
      8'h0D: return 8'h01;
      8'h0E: return 8'h02;
      8'h2C: return 8'h04;
      8'h28: return 8'h08;
      8'h1A: return 8'h10;
      8'h16: return 8'h20;
      8'h04: return 8'h40;
      8'h07: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  bit         m_strobe = 1'b0;
  logic [7:0] m_snap = 8'h00;
  int         m_reads = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_oe = 1'b0;

  always @(posedge Clk or negedge Reset_n) begin
    logic [7:0] cur;
    logic       rd;
    logic       bit0;
    if (!Reset_n) begin
      m_strobe = 1'b0; m_snap = 8'h00; m_reads = 0; m_dout = 8'h00; m_oe = 1'b0;
    end else begin
      cur = map_key(keycode);
      rd  = bus.cpu_cycle_en && bus.cpu_rw_n;
      m_oe = 1'b0;
      if (rd && bus.cpu_addr == 16'h4016) begin
        if (m_strobe) bit0 = cur[0];
        else begin
          bit0 = (m_reads < 8) ? m_snap[m_reads] : 1'b1;
          m_reads++;
        end
        m_dout = {7'b0100000, bit0};
        m_oe = 1'b1;
      end else if (rd && bus.cpu_addr == 16'h4017) begin
        m_dout = 8'h40;
        m_oe = 1'b1;
      end
      if (m_strobe) begin
        m_snap = cur;
        m_reads = 0;
      end
      if (bus.cpu_cycle_en && !bus.cpu_rw_n && bus.cpu_addr == 16'h4016)
        m_strobe = bus.cpu_dout[0];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cyc_buttons", buttons_debug, map_key(keycode));
      check("cyc_count", {4'h0, read_count}, (m_reads > 8) ? 8'd8 : 8'(m_reads));
      check("cyc_oe", {7'h0, bus.data_oe}, {7'h0, m_oe});
      check("cyc_dout", bus.data_out, m_dout);
    end
  end

  task automatic bus_idle();
    bus.cpu_cycle_en = 1'b0;
    bus.cpu_rw_n = 1'b1;
    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge Clk); #2;
    bus.cpu_cycle_en = 1'b1; bus.cpu_rw_n = 1'b0; bus.cpu_addr = a; bus.cpu_dout = d;
    @(posedge Clk); #2;
    bus_idle();
  endtask

  task automatic bus_read(input logic [15:0] a, input logic en, output logic [7:0] d, output logic oe);
    @(posedge Clk); #2;
    bus.cpu_cycle_en = en; bus.cpu_rw_n = 1'b1; bus.cpu_addr = a;
    @(posedge Clk); #1;
    d = bus.data_out; oe = bus.data_oe;
    #1;
    bus_idle();
  endtask

  task automatic set_key(input logic [7:0] k);
    @(posedge Clk); #2;
    keycode = k;
  endtask

  task automatic load(input logic [7:0] k);
    set_key(k);
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
  endtask

  logic [7:0] d;
  logic       oe;
  logic [7:0] seq31 [8] = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
  logic [7:0] keys  [10] = '{8'h0D, 8'h0E, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h05, 8'hFF};
  logic [7:0] keyexp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h00};

  initial begin
    bus_idle();
    #12;
    check("reset_dout", bus.data_out, 8'h00);
    check("reset_oe", {7'h0, bus.data_oe}, 8'h00);
    check("reset_count", {4'h0, read_count}, 8'h00);
    Reset_n = 1'b1;
    cmp_en = 1'b1;

    // Key map with zero latency
    for (int i = 0; i < 10; i++) begin
      set_key(keys[i]);
      #1;
      check("map", buttons_debug, keyexp[i]);
    end

    // First read after reset without strobe
    set_key(8'h0D);
    bus_read(16'h4016, 1'b1, d, oe);
    check("first_read", d, 8'h40);
    check("first_read_oe", {7'h0, oe}, 8'h01);

    // A pressed, eight reads
    load(8'h0D);
    for (int i = 0; i < 8; i++) begin
      bus_read(16'h4016, 1'b1, d, oe);
      $display("read31 %0d data=%02h oe=%0b", i, d, oe);
      check("seq_a", d, seq31[i]);
    end
    #1 check("seq_a_count", {4'h0, read_count}, 8'h08);

    // Right pressed, ten reads
    load(8'h07);
    for (int i = 0; i < 10; i++) begin
      bus_read(16'h4016, 1'b1, d, oe);
      $display("read32 %0d data=%02h", i, d);
      check("seq_right", {7'h0, d[0]}, (i >= 7) ? 8'h01 : 8'h00);
    end

    // Strobe held high, live A
    set_key(8'h0D);
    bus_write(16'h4016, 8'h01);
    bus_read(16'h4016, 1'b1, d, oe);
    check("strobe_a", d, 8'h41);
    set_key(8'h00);
    bus_read(16'h4016, 1'b1, d, oe);
    check("strobe_none", d, 8'h40);
    check("strobe_count", {4'h0, read_count}, 8'h00);
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);

    // Start latched, later A ignored
    load(8'h28);
    set_key(8'h0D);
    for (int i = 0; i < 4; i++) begin
      bus_read(16'h4016, 1'b1, d, oe);
      $display("read34 %0d data=%02h", i, d);
      check("latched_start", {7'h0, d[0]}, (i == 3) ? 8'h01 : 8'h00);
    end
    // Redundant write of 0 must not reset the count
    bus_write(16'h4016, 8'h00);
    #1 check("redundant_w0", {4'h0, read_count}, 8'h04);

    // Other address / disabled cycle / foreign write
    bus_read(16'h4017, 1'b1, d, oe);
    check("p1_read", d, 8'h40);
    check("p1_read_oe", {7'h0, oe}, 8'h01);
    bus_read(16'h4016, 1'b0, d, oe);
    check("dis_read_oe", {7'h0, oe}, 8'h00);
    check("dis_read_hold", d, 8'h40);
    bus_write(16'h2000, 8'h01);
    #1 check("foreign_w_count", {4'h0, read_count}, 8'h04);
    bus_read(16'h4016, 1'b1, d, oe);
    check("after_foreign", d, 8'h40);

    // Reset mid-sequence
    load(8'h0D);
    for (int i = 0; i < 3; i++) bus_read(16'h4016, 1'b1, d, oe);
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    check("arst_dout", bus.data_out, 8'h00);
    check("arst_oe", {7'h0, bus.data_oe}, 8'h00);
    check("arst_count", {4'h0, read_count}, 8'h00);
    @(posedge Clk); #2;
    Reset_n = 1'b1;
    bus_read(16'h4016, 1'b1, d, oe);
    check("post_rst_read", d, 8'h40);

    repeat (3) @(posedge Clk);
    #3;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nes_joypad_port.md
NES_JOYPAD_PORT -- requirements
Module: nes_joypad_port

Interface
REQ-001 SHALL have parameter PORT_ADDR, default 16'h4016, meaning the CPU address of the player-1 controller register.
REQ-002 SHALL have parameter OPEN_BUS, default 8'h40, meaning the value driven on read-data bits [7:1].
REQ-003 Clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 keycode  input  8  USB HID keycode currently held, 8'h00 = none.
REQ-006 cpu_cycle_en  input  1  one-Clk pulse per CPU bus cycle; bus inputs are sampled only while it is high.
REQ-007 cpu_addr  input  16  CPU address bus.
REQ-008 cpu_rw_n  input  1  CPU read (1) / write (0).
REQ-009 cpu_dout  input  8  CPU write data.
REQ-010 data_out  output  8  registered read data returned to the CPU.
REQ-011 data_oe  output  1  one-Clk pulse marking data_out as valid for the current read.
REQ-012 buttons_debug  output  8  live mapped button vector, for LEDR.
REQ-013 read_count  output  4  number of serial reads since the last load, saturating at 8.

Function
REQ-014 SHALL map keycode combinationally to buttons[7:0] = {Right,Left,Down,Up,Start,Select,B,A}, with one bit set per code: 8'h0D→A, 8'h0E→B, 8'h2C→Select, 8'h28→Start, 8'h1A→Up, 8'h16→Down, 8'h04→Left, 8'h07→Right; every other code SHALL map to 8'h00.
REQ-015 buttons_debug SHALL equal buttons with zero latency.
REQ-016 A write hit (cpu_cycle_en & ~cpu_rw_n & cpu_addr==PORT_ADDR) SHALL set the strobe register to cpu_dout[0] on the next edge.
REQ-017 While strobe=1, the shift register SHALL be reloaded from buttons every Clk and read_count SHALL be held at 0.
REQ-018 On a write hit that takes strobe from 1 to 0, the shift register SHALL load buttons as sampled in that same cycle, and read_count SHALL be set to 0.
REQ-019 A read hit (cpu_cycle_en & cpu_rw_n & cpu_addr==PORT_ADDR) SHALL register data_out = {OPEN_BUS[7:1], shreg[0]} and pulse data_oe for exactly one Clk; latency from read hit to data_oe is 1 Clk.
REQ-020 On a read hit with strobe=0, the shift register SHALL shift right with a 1 filled into bit 7, and read_count SHALL increment, saturating at 8.
REQ-021 On a read hit with strobe=1, data_out[0] SHALL be the live buttons[0] (A), with no shift and no count change.
REQ-022 After 8 reads without a reload, every further read SHALL return data_out[0]=1.
REQ-023 A read hit at PORT_ADDR+1 SHALL return {OPEN_BUS[7:1],1'b0} with the data_oe pulse and SHALL NOT alter any state.
REQ-024 Accesses with cpu_cycle_en=0, or at any other address, SHALL leave all state and data_out unchanged, and data_oe SHALL be 0.
REQ-025 data_out SHALL hold its last value between reads.
REQ-026 A keycode change while strobe=0 SHALL NOT affect the shift register until the next reload.
REQ-027 A write of 1 while strobe is already 1, or a write of 0 while strobe is already 0, SHALL NOT reload the register or reset read_count.

Reset
REQ-028 On Reset_n=0, asynchronously: strobe=0, shreg=8'h00, read_count=0, data_out=8'h00, data_oe=0.
REQ-029 After release, the first read without a prior strobe SHALL return {OPEN_BUS[7:1],0}.
REQ-030 Reset asserted mid-sequence SHALL abort it; no pre-reset state SHALL persist.

Verification
REQ-031 keycode=8'h0D, write 1 then 0 to 16'h4016, 8 reads → data_out sequence 8'h41,40,40,40,40,40,40,40; read_count=8.
REQ-032 keycode=8'h07, load, 10 reads → bit0 sequence 0,0,0,0,0,0,0,1,1,1.
REQ-033 Strobe held at 1 with keycode switching 8'h0D→8'h00 between reads → reads return 8'h41 then 8'h40; read_count stays 0.
REQ-034 Load with keycode=8'h28, change keycode to 8'h0D, 4 reads → bit0 0,0,0,1 (Start latched, A ignored).
REQ-035 Read at 16'h4017, read at 16'h4016 with cpu_cycle_en=0, write at 16'h2000 → 8'h40 with one data_oe pulse / no data_oe / no state change.
REQ-036 Reset_n pulsed low after 3 reads → all outputs 0 immediately; next read returns 8'h40.
